fb_pixel_writer: RTL
====================

// Module: fb_pixel_writer
// PURPOSE
//  Host-side write port into the packed 80x60 R/G/B framebuffer RAMs (the writer end of the display-read path).
//  Accepts single-pixel writes (x,y,rgb) over a valid/ready handshake and performs blanking-only read-modify-write.
//  Also runs a whole-frame clear/fill engine. Owns the RAM bus only while display_on==0; the top muxes on mem_own.
// PARAMETERS
//  RAMLENGTH   800               words per colour RAM
//  DATA_WIDTH  6                 pixels packed per word (RAMLENGTH*DATA_WIDTH = FB_W*FB_H)
//  FB_W        80                framebuffer width in pixels
//  FB_H        60                framebuffer height in pixels
//  ADDR_WIDTH  $clog2(RAMLENGTH) RAM address width
//  X_WIDTH     $clog2(FB_W)      px_x width
//  Y_WIDTH     $clog2(FB_H)      px_y width
// PORTS
//  clk                  in   1           system clock
//  reset                in   1           asynchronous, active-high reset
//  display_on           in   1           1 = active video, RAM bus belongs to display codec
//  px_valid             in   1           pixel write request
//  px_ready             out  1           writer can accept a pixel this cycle
//  px_x                 in   X_WIDTH     pixel column
//  px_y                 in   Y_WIDTH     pixel row
//  px_rgb               in   3           {R,G,B} bit for the pixel
//  clr_req              in   1           start whole-frame fill (sampled in IDLE)
//  clr_rgb              in   3           {R,G,B} fill colour
//  clr_done             out  1           1-cycle pulse, fill finished
//  err_oob              out  1           1-cycle pulse, accepted pixel out of range, dropped
//  busy                 out  1           state != IDLE
//  mem_own              out  1           writer is driving mem_addr/mem_we this cycle
//  mem_addr             out  ADDR_WIDTH  RAM address (shared by all three RAMs)
//  mem_we               out  1           RAM write strobe
//  memR/G/B_wdata       out  DATA_WIDTH  write data per colour RAM
//  memR/G/B_rdata       in   DATA_WIDTH  RAM read data, valid 1 cycle after mem_addr
// BEHAVIOUR
//  Packing: p = y*FB_W + x; word = p / DATA_WIDTH; bit = p % DATA_WIDTH. Computed and registered at accept.
//  Reset: state=IDLE, clear counter=0; all outputs 0 while reset is high; a partial clear is not resumed.
//  px_ready = (state==IDLE) && !clr_req. clr_req wins over a simultaneous px_valid.
//  States:
//   IDLE  : clr_req -> CLEAR (cnt=0).
//           Else px_valid&&px_ready -> x>=FB_W or y>=FB_H: err_oob pulse next cycle, stay IDLE;
//           otherwise latch word/bit/rgb, go WAIT.
//   WAIT  : display_on==0 -> RD; else hold.
//   RD    : mem_own=1, mem_addr=word, mem_we=0. display_on==1 -> WAIT; else -> WR.
//   WR    : mem_own=1, mem_we=1, same addr; each colour wdata = rdata with [bit] replaced by that colour of rgb.
//           display_on==1 -> WAIT (no write, mem_we=0, retry); else write commits, -> IDLE.
//   CLEAR : while display_on==0: mem_own=1, mem_we=1, mem_addr=cnt, wdata={DATA_WIDTH{clr_rgb[c]}}, cnt++.
//           While display_on==1: mem_own=0, cnt holds.
//           After writing cnt==RAMLENGTH-1: clr_done pulse, -> IDLE. clr_rgb is latched at entry.
//  Latency: pixel accepted at T with blanking throughout: mem_we at T+3, px_ready high at T+4.
//  Full clear takes RAMLENGTH blanking cycles.
//  mem_own=0 outside RD/WR/CLEAR-active; mem_we never 1 when display_on==1 or mem_own==0.
//  No write is ever partially applied: the three colour RAMs are always written in the same cycle.
// TESTING
//  1 Blanking, write (x=5,y=0,rgb=3'b101), RAMs all-0 -> word0: R=6'b100000, G=0, B=6'b100000;
//    mem_we at T+3.
//  2 Write (x=79,y=59,rgb=7) -> addr 799, bit 5 set in all three RAMs; other bits of preloaded
//    word 6'b010101 unchanged.
//  3 Write (x=80,y=0) -> err_oob pulse, no mem_we, px_ready back high next cycle.
//  4 display_on rises in WR -> no write that cycle, returns to WAIT; completes once blanking resumes.
//  5 clr_req with clr_rgb=3'b010 and toggling display_on -> 800 writes of G=6'h3F, R=B=0;
//    none while display_on; single clr_done pulse.
//  6 Assert reset mid-CLEAR at cnt=400 -> outputs 0 immediately; after release IDLE, px_ready=1,
//    no further writes.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// Host-side writer for the packed 80x60 R/G/B framebuffer RAMs.
// It accepts single-pixel writes over a valid/ready handshake and applies
// each one as a read-modify-write while the display is blanked. It also
// runs a whole-frame fill engine. The RAM bus is driven only during
// blanking, and the top level muxes the bus on mem_own.
module fb_pixel_writer #(
    parameter int RAMLENGTH  = 800,
    parameter int DATA_WIDTH = 6,
    parameter int FB_W       = 80,
    parameter int FB_H       = 60,
    parameter int ADDR_WIDTH = $clog2(RAMLENGTH),
    parameter int X_WIDTH    = $clog2(FB_W),
    parameter int Y_WIDTH    = $clog2(FB_H)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  display_on,
    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [X_WIDTH-1:0]    px_x,
    input  logic [Y_WIDTH-1:0]    px_y,
    input  logic [2:0]            px_rgb,
    input  logic                  clr_req,
    input  logic [2:0]            clr_rgb,
    output logic                  clr_done,
    output logic                  err_oob,
    output logic                  busy,
    output logic                  mem_own,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] memR_wdata,
    output logic [DATA_WIDTH-1:0] memG_wdata,
    output logic [DATA_WIDTH-1:0] memB_wdata,
    input  logic [DATA_WIDTH-1:0] memR_rdata,
    input  logic [DATA_WIDTH-1:0] memG_rdata,
    input  logic [DATA_WIDTH-1:0] memB_rdata
);

    localparam int PIX_W = $clog2(FB_W * FB_H);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_WR,
        S_CLEAR
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [BIT_W-1:0]      bit_q;
    logic [2:0]            rgb_q;
    logic [2:0]            clr_rgb_q;
    logic                  err_n, done_n;

    logic                  accept;
    logic                  out_of_range;
    logic [PIX_W-1:0]      pix;
    logic [ADDR_WIDTH-1:0] pix_word;
    logic [BIT_W-1:0]      pix_bit;

    // Handshake and pixel-to-word packing for the incoming request.
    assign px_ready     = (state == S_IDLE) && !clr_req && !reset;
    assign accept       = px_valid && px_ready;
    assign out_of_range = ({1'b0, px_x} >= (X_WIDTH + 1)'(FB_W)) ||
                          ({1'b0, px_y} >= (Y_WIDTH + 1)'(FB_H));
    assign pix          = PIX_W'(px_y) * PIX_W'(FB_W) + PIX_W'(px_x);
    assign pix_word     = ADDR_WIDTH'(pix / PIX_W'(DATA_WIDTH));
    assign pix_bit      = BIT_W'(pix % PIX_W'(DATA_WIDTH));
    assign busy         = (state != S_IDLE);

    // State register, fill counter and the one-cycle status pulses.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, regardless of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            err_oob  <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            err_oob  <= err_n;
            clr_done <= done_n;
        end
    end

    // Latch the packed target of an accepted pixel and the fill colour at clear entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q    <= '0;
            bit_q     <= '0;
            rgb_q     <= '0;
            clr_rgb_q <= '0;
        end else if (state == S_IDLE) begin
            if (clr_req) begin
                clr_rgb_q <= clr_rgb;
            end else if (accept && !out_of_range) begin
                word_q <= pix_word;
                bit_q  <= pix_bit;
                rgb_q  <= px_rgb;
            end
        end
    end

    // Next-state logic and RAM bus drive; the bus is released whenever video is active.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        err_n      = 1'b0;
        done_n     = 1'b0;
        mem_own    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        memR_wdata = '0;
        memG_wdata = '0;
        memB_wdata = '0;

        unique case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_n = S_CLEAR;
                    cnt_n   = '0;
                end else if (accept) begin
                    if (out_of_range) err_n   = 1'b1;
                    else              state_n = S_WAIT;
                end
            end

            S_WAIT: begin
                if (!display_on) state_n = S_RD;
            end

            S_RD: begin
                mem_addr = word_q;
                mem_own  = !display_on;
                state_n  = display_on ? S_WAIT : S_WR;
            end

            S_WR: begin
                // Read data for word_q arrived this cycle; replace just one bit per colour.
                mem_addr          = word_q;
                memR_wdata        = memR_rdata;
                memG_wdata        = memG_rdata;
                memB_wdata        = memB_rdata;
                memR_wdata[bit_q] = rgb_q[2];
                memG_wdata[bit_q] = rgb_q[1];
                memB_wdata[bit_q] = rgb_q[0];
                if (display_on) begin
                    state_n = S_WAIT;
                end else begin
                    mem_own = 1'b1;
                    mem_we  = 1'b1;
                    state_n = S_IDLE;
                end
            end

            S_CLEAR: begin
                mem_addr   = cnt;
                memR_wdata = {DATA_WIDTH{clr_rgb_q[2]}};
                memG_wdata = {DATA_WIDTH{clr_rgb_q[1]}};
                memB_wdata = {DATA_WIDTH{clr_rgb_q[0]}};
                if (!display_on) begin
                    mem_own = 1'b1;
                    mem_we  = 1'b1;
                    if (cnt == ADDR_WIDTH'(RAMLENGTH - 1)) begin
                        cnt_n   = '0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule
